lfsr_stream: RTL



---
 rtl/lfsr_stream.sv | 109 ++++++++++
 1 files changed

// File: rtl/lfsr_stream.sv
// -----------------------------------------------------------------------------
// lfsr_stream
//
// Galois LFSR pseudo-random word source with a valid/ready output stream.
// The LFSR can be reseeded at run time. A counter tracks how many words the
// consumer has accepted.
//
// Parameters
//   WIDTH : LFSR and output width (3..64)
//   TAPS  : Galois tap mask. Bit i (1..WIDTH-1) set gives
//           next[i] = cur[i-1] ^ fb. Bit 0 is ignored.
//   SEED  : reset state. It is also used in place of any all-zero seed.
//           Must be non-zero.
//   STEPS : LFSR shifts applied per emitted word (1..WIDTH)
//
// Ports
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   seed_load  : load seed_value and flush the output word
//   seed_value : new seed, sampled only while seed_load = 1
//   dout       : current pseudo-random word
//   dout_valid : dout holds a word
//   dout_ready : consumer accepts dout this cycle
//   seed_zero  : sticky flag, set when a zero seed was replaced by SEED
//   word_cnt   : accepted words since the last reset or seed load (wraps)
// -----------------------------------------------------------------------------
module lfsr_stream #(
  parameter int               WIDTH = 32,
  parameter logic [63:0]      TAPS  = 64'h0000_0000_0040_0006,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             seed_zero,
  output logic [31:0]      word_cnt
);

  // One Galois shift. The MSB feeds back into bit 0 and into every tapped bit.
  function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] s);
    logic             fb;
    logic [WIDTH-1:0] n;
    fb   = s[WIDTH-1];
    n    = '0;
    n[0] = fb;
    for (int i = 1; i < WIDTH; i++) begin
      n[i] = s[i-1] ^ (TAPS[i] & fb);
    end
    return n;
  endfunction

  // STEPS shifts unrolled into a single combinational cycle.
  function automatic logic [WIDTH-1:0] lfsr_adv(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = s;
    for (int k = 0; k < STEPS; k++) begin
      n = lfsr_shift(n);
    end
    return n;
  endfunction

  // state always holds the next word to be emitted.
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_adv;
  logic             fill;
  logic             accept;
  logic             seed_is_zero;

  assign state_adv    = lfsr_adv(state);
  // fill and accept depend on registered dout_valid and the dout_ready input.
  // They only steer the next register update, so dout_ready never reaches
  // dout or dout_valid combinationally.
  assign fill         = !dout_valid || dout_ready;
  assign accept       = dout_valid && dout_ready;
  assign seed_is_zero = (seed_value == '0);

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= SEED;
      dout       <= '0;
      dout_valid <= 1'b0;
      seed_zero  <= 1'b0;
      word_cnt   <= '0;
    end else if (seed_load) begin
      // A reseed flushes the output word and restarts the count. A handshake
      // that completes in this same cycle is not counted.
      state      <= seed_is_zero ? SEED : seed_value;
      seed_zero  <= seed_zero | seed_is_zero;
      dout_valid <= 1'b0;
      word_cnt   <= '0;
    end else begin
      if (accept) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (fill) begin
        dout       <= state;
        state      <= state_adv;
        dout_valid <= 1'b1;
      end
    end
  end

endmodule
